norm2_main: RTL and testbench

//  Sum-of-squares (squared L2 norm) engine over an on-chip 1024x27-bit signed array.
//  The host loads the array through a shared port while controlArr=1.
//  A one-cycle r_enable pulse starts the loop; w_enable pulses when result holds the sum.

---
 rtl/norm2_main.sv | 151 +++++++++++++++
 tb/tb_norm2_main.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/norm2_main.sv
// ----------------------------------------------------------------------------
// norm2_main
//  Squared L2 norm engine over an on-chip signed array. The host fills the
//  array through a shared port while controlArr=1. A start pulse on r_enable
//  then accumulates sum(a[k]^2) for k = init_i .. N_ELEMS-1 onto init_acc, and
//  w_enable pulses for one cycle while result holds the final sum.
//
// Ports
//  clk                  in   clock, rising edge
//  rst_n                in   asynchronous active-low reset
//  r_enable             in   start pulse, samples init_i / init_acc (IDLE only)
//  controlArr           in   1 = host owns the array port, 0 = engine owns it
//  init_i               in   starting loop index
//  init_acc             in   starting accumulator value
//  controlArrWEnable_a  in   host write enable (only while controlArr=1)
//  controlArrAddr_a     in   host address
//  controlArrWData_a    in   host write data (signed)
//  controlArrRData_a    out  host read data, registered (signed)
//  w_enable             out  one-cycle completion pulse
//  result               out  final accumulator, held until the next completion
// ----------------------------------------------------------------------------
module norm2_main #(
  parameter int N_ELEMS = 1000,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 27,
  parameter int ACC_W   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     r_enable,
  input  logic                     controlArr,
  input  logic [ACC_W-1:0]         init_i,
  input  logic [ACC_W-1:0]         init_acc,
  input  logic                     controlArrWEnable_a,
  input  logic [ADDR_W-1:0]        controlArrAddr_a,
  input  logic signed [DATA_W-1:0] controlArrWData_a,
  output logic signed [DATA_W-1:0] controlArrRData_a,
  output logic                     w_enable,
  output logic [ACC_W-1:0]         result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_MAC,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [ACC_W-1:0] i_q, i_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;

  // Array storage and its two read registers.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] eng_rd_q;
  logic [DATA_W-1:0] host_rd_q;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;

  logic signed [2*DATA_W-1:0] d_ext;
  logic signed [2*DATA_W-1:0] sq;

  // Single shared port: host address while it owns the array, loop index otherwise.
  assign ram_addr = controlArr ? controlArrAddr_a : i_q[ADDR_W-1:0];
  assign ram_we   = controlArr & controlArrWEnable_a;

  // Engine read register only reloads while the engine owns the port, so a
  // read issued before a host stall is still valid when the stall ends.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_addr] <= controlArrWData_a;
    end
    if (!controlArr) begin
      eng_rd_q <= mem_q[ram_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rd_q <= '0;
    end else if (controlArr) begin
      host_rd_q <= mem_q[ram_addr];
    end
  end

  // Full-width signed square; non-negative, so widening to ACC_W is exact.
  assign d_ext = (2*DATA_W)'($signed(eng_rd_q));
  assign sq    = d_ext * d_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // result is loaded on the edge into DONE so it is already valid while
  // w_enable (decoded from DONE) is high.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (r_enable && !controlArr) begin
          i_d     = init_i;
          acc_d   = init_acc;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!controlArr) begin
          if (i_q >= ACC_W'(N_ELEMS)) begin
            result_d = acc_q;
            state_d  = S_DONE;
          end else begin
            state_d = S_MAC;
          end
        end
      end
      S_MAC: begin
        if (!controlArr) begin
          acc_d   = acc_q + ACC_W'(sq);
          i_d     = i_q + ACC_W'(1);
          state_d = S_ADDR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign w_enable          = (state_q == S_DONE);
  assign result            = result_q;
  assign controlArrRData_a = $signed(host_rd_q);

endmodule

// File: tb/tb_norm2_main.sv
module tb_norm2_main;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               r_enable;
  logic               controlArr;
  logic [63:0]        init_i;
  logic [63:0]        init_acc;
  logic               controlArrWEnable_a;
  logic [9:0]         controlArrAddr_a;
  logic signed [26:0] controlArrWData_a;
  logic signed [26:0] controlArrRData_a;
  logic               w_enable;
  logic [63:0]        result;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  norm2_main #(
    .N_ELEMS(1000),
    .ADDR_W (10),
    .DATA_W (27),
    .ACC_W  (64)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .r_enable           (r_enable),
    .controlArr         (controlArr),
    .init_i             (init_i),
    .init_acc           (init_acc),
    .controlArrWEnable_a(controlArrWEnable_a),
    .controlArrAddr_a   (controlArrAddr_a),
    .controlArrWData_a  (controlArrWData_a),
    .controlArrRData_a  (controlArrRData_a),
    .w_enable           (w_enable),
    .result             (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic [9:0] a, input logic signed [26:0] d);
    controlArr          = 1'b1;
    controlArrWEnable_a = 1'b1;
    controlArrAddr_a    = a;
    controlArrWData_a   = d;
    tick();
    controlArrWEnable_a = 1'b0;
  endtask

  task automatic fill(input logic signed [26:0] val, input bit ramp);
    for (int k = 0; k < 1000; k++) begin
      hwrite(10'(k), ramp ? 27'(k) : val);
    end
    controlArr = 1'b0;
  endtask

  // Start a run, optionally hand the port to the host for stall_len cycles
  // starting stall_at cycles after the start, then check latency and result.
  task automatic run(input string tag, input logic [63:0] ii, input logic [63:0] acc,
                     input logic [63:0] exp_res, input int exp_lat,
                     input int stall_at, input int stall_len);
    int lat;
    bit seen;
    controlArr = 1'b0;
    init_i     = ii;
    init_acc   = acc;
    r_enable   = 1'b1;
    tick();
    r_enable = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 5000) begin
      tick();
      lat++;
      if (stall_len > 0 && lat == stall_at) controlArr = 1'b1;
      if (stall_len > 0 && lat == stall_at + stall_len) controlArr = 1'b0;
      if (w_enable) seen = 1'b1;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    tick();
    check({tag, " pulse_width"}, 64'(w_enable), 64'd0);
  endtask

  initial begin
    int pulses;
    rst_n               = 1'b0;
    r_enable            = 1'b0;
    controlArr          = 1'b0;
    init_i              = '0;
    init_acc            = '0;
    controlArrWEnable_a = 1'b0;
    controlArrAddr_a    = '0;
    controlArrWData_a   = '0;
    #1;
    check("reset w_enable", 64'(w_enable), 64'd0);
    check("reset result", result, 64'd0);
    check("reset rdata", 64'(controlArrRData_a), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Host write then readback, positive and negative values.
    hwrite(10'd7, 27'sd12345);
    hwrite(10'd8, -27'sd5);
    controlArrAddr_a = 10'd7;
    tick();
    check("readback a7", 64'(controlArrRData_a), 64'd12345);
    controlArrAddr_a = 10'd8;
    tick();
    check("readback a8", 64'(controlArrRData_a), 64'hFFFF_FFFF_FFFF_FFFB);

    // Start request while the host owns the port must be ignored.
    pulses   = 0;
    r_enable = 1'b1;
    tick();
    r_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (w_enable) pulses++;
      tick();
    end
    controlArr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (w_enable) pulses++;
      tick();
    end
    check("host-owned start ignored", 64'(pulses), 64'd0);

    // Ramp: sum k^2, k=0..999.
    fill('0, 1'b1);
    run("ramp", 64'd0, 64'd0, 64'd332833500, 2001, 0, 0);

    // All maximum positive values.
    fill(27'sd67108863, 1'b0);
    run("max", 64'd0, 64'd0, 64'd1000 * (64'd67108863 * 64'd67108863), 2001, 0, 0);

    // Negative data.
    fill(-27'sd3, 1'b0);
    run("neg", 64'd0, 64'd0, 64'd9000, 2001, 0, 0);

    // Tail of the array with a non-zero starting accumulator.
    hwrite(10'd998, 27'sd2);
    hwrite(10'd999, 27'sd3);
    controlArr = 1'b0;
    run("tail", 64'd998, 64'd5, 64'd18, 5, 0, 0);
    run("at_bound", 64'd1000, 64'd77, 64'd77, 1, 0, 0);
    run("huge_i", 64'h8000_0000_0000_0000, 64'd3, 64'd3, 1, 0, 0);

    // Host stall mid-loop: 998*9 + 4 + 9 = 8995, 20 extra cycles.
    run("stall", 64'd0, 64'd0, 64'd8995, 2021, 50, 20);

    // Reset mid-loop aborts the run.
    controlArr = 1'b0;
    init_i     = '0;
    init_acc   = '0;
    r_enable   = 1'b1;
    tick();
    r_enable = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    check("midreset result", result, 64'd0);
    check("midreset w_enable", 64'(w_enable), 64'd0);
    tick();
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 2100; c++) begin
      if (w_enable) pulses++;
      tick();
    end
    check("no pulse after abort", 64'(pulses), 64'd0);
    run("restart", 64'd0, 64'd0, 64'd8995, 2001, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
